// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared request and tag-FIFO entry types for the load/store unit.
// The struct field widths are the upper bound for lsu_ctrl's width parameters.
package lsu_ctrl_pkg;
    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;
    localparam int LSU_TAG_W  = 5;

    typedef struct packed {
        logic                  store;
        logic                  is_byte;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_TAG_W-1:0]  tag;
    } lsu_req_s;

    typedef struct packed {
        logic                 store;
        logic                 is_byte;
        logic [LSU_TAG_W-1:0] tag;
    } lsu_tag_entry_s;
endpackage

// File: rtl/lsu_tag_fifo.sv
// lsu_tag_fifo: in-order FIFO of outstanding transaction tags; push and pop
// may coincide even when full, which keeps the LSU at one request per cycle.
module lsu_tag_fifo
    import lsu_ctrl_pkg::*;
#(
    parameter int DEPTH_P = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  lsu_tag_entry_s               entry_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output lsu_tag_entry_s               head_o,
    output logic [$clog2(DEPTH_P+1)-1:0] count_o
);
    localparam int PW = DEPTH_P > 1 ? $clog2(DEPTH_P) : 1;
    localparam int CW = $clog2(DEPTH_P+1);

    lsu_tag_entry_s mem_q [DEPTH_P];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_d    = push_i ? (wr_q == PW'(DEPTH_P-1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = pop_i ? (rd_q == PW'(DEPTH_P-1) ? '0 : rd_q + 1'b1) : rd_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= entry_i;
    end

    assign full_o  = count_q == CW'(DEPTH_P);
    assign empty_o = count_q == '0;
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with a registered issue slot and in-order commit.
// Define LSU_BYTE_SEXT_EN to sign-extend byte loads; otherwise they zero-extend.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DEPTH_P      = 2,
    parameter int ADDR_WIDTH_P = 32,
    parameter int DATA_WIDTH_P = 32,
    parameter int TAG_WIDTH_P  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_store_i,
    input  logic                         req_byte_i,
    input  logic [ADDR_WIDTH_P-1:0]      req_addr_i,
    input  logic [DATA_WIDTH_P-1:0]      req_wdata_i,
    input  logic [TAG_WIDTH_P-1:0]       req_tag_i,
    output logic                         mem_valid_o,
    output logic                         mem_wen_o,
    output logic                         mem_byte_o,
    output logic [ADDR_WIDTH_P-1:0]      mem_addr_o,
    output logic [DATA_WIDTH_P-1:0]      mem_wdata_o,
    input  logic                         mem_yumi_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_WIDTH_P-1:0]      mem_rdata_i,
    output logic                         mem_ryumi_o,
    output logic                         wb_valid_o,
    output logic                         wb_we_o,
    output logic [TAG_WIDTH_P-1:0]       wb_tag_o,
    output logic [DATA_WIDTH_P-1:0]      wb_data_o,
    input  logic                         wb_ready_i,
    output logic [$clog2(DEPTH_P+1)-1:0] outstanding_o,
    output logic                         busy_o,
    output logic                         error_o
);
    lsu_req_s       req_s, slot_q, slot_d;
    lsu_tag_entry_s entry_s, head;
    logic slot_v_q, slot_v_d, err_q, err_d;
    logic accept, pop, stray, fifo_full, fifo_empty;
    logic [DATA_WIDTH_P-1:0] byte_ext;

`ifdef LSU_BYTE_SEXT_EN
    assign byte_ext = {{(DATA_WIDTH_P-8){mem_rdata_i[7]}}, mem_rdata_i[7:0]};
`else
    assign byte_ext = {{(DATA_WIDTH_P-8){1'b0}}, mem_rdata_i[7:0]};
`endif

    assign req_s = '{store: req_store_i, is_byte: req_byte_i, addr: LSU_ADDR_W'(req_addr_i),
                     wdata: LSU_DATA_W'(req_wdata_i), tag: LSU_TAG_W'(req_tag_i)};
    assign entry_s = '{store: req_store_i, is_byte: req_byte_i, tag: LSU_TAG_W'(req_tag_i)};

    // A commit in the same cycle frees a FIFO slot, so ready may bypass full.
    always_comb begin
        wb_valid_o  = mem_rvalid_i && !fifo_empty;
        pop         = wb_valid_o && wb_ready_i;
        stray       = mem_rvalid_i && fifo_empty;
        mem_ryumi_o = pop || stray;
        req_ready_o = (!fifo_full || pop) && (!slot_v_q || mem_yumi_i);
        accept      = req_valid_i && req_ready_o;
        slot_v_d    = accept || (slot_v_q && !mem_yumi_i);
        slot_d      = accept ? req_s : slot_q;
        err_d       = err_q || stray;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q <= 1'b0;
            slot_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_q   <= slot_d;
            err_q    <= err_d;
        end
    end

    lsu_tag_fifo #(.DEPTH_P(DEPTH_P)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .entry_i (entry_s),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head),
        .count_o (outstanding_o)
    );

    assign mem_valid_o = slot_v_q;
    assign mem_wen_o   = slot_q.store;
    assign mem_byte_o  = slot_q.is_byte;
    assign mem_addr_o  = ADDR_WIDTH_P'(slot_q.addr);
    assign mem_wdata_o = DATA_WIDTH_P'(slot_q.wdata);
    assign wb_we_o     = !head.store;
    assign wb_tag_o    = TAG_WIDTH_P'(head.tag);
    assign wb_data_o   = head.store ? '0 : head.is_byte ? byte_ext : mem_rdata_i;
    assign busy_o      = outstanding_o != '0 || slot_v_q;
    assign error_o     = err_q;
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DEPTH_P, default 2: maximum outstanding memory transactions, legal range 1..8.
REQ-002 Parameter ADDR_WIDTH_P, default 32: data-memory address width.
REQ-003 Parameter DATA_WIDTH_P, default 32: read/write data width.
REQ-004 Parameter TAG_WIDTH_P, default 5: destination-register tag width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid_i  input  1  core presents a LD/ST.
REQ-008 req_ready_o  output  1  unit accepts the request this cycle.
REQ-009 req_store_i, req_byte_i  input  1 each  store-not-load; byte-not-word.
REQ-010 req_addr_i  input  ADDR_WIDTH_P  address; req_wdata_i  input  DATA_WIDTH_P  store data; req_tag_i  input  TAG_WIDTH_P  destination register.
REQ-011 mem_valid_o, mem_wen_o, mem_byte_o  output  1 each  request to data memory.
REQ-012 mem_addr_o  output  ADDR_WIDTH_P; mem_wdata_o  output  DATA_WIDTH_P.
REQ-013 mem_yumi_i  input  1  memory accepted the issued request.
REQ-014 mem_rvalid_i  input  1; mem_rdata_i  input  DATA_WIDTH_P  memory response.
REQ-015 mem_ryumi_o  output  1  unit consumes the response.
REQ-016 wb_valid_o  output  1; wb_we_o  output  1; wb_tag_o  output  TAG_WIDTH_P; wb_data_o  output  DATA_WIDTH_P  commit port.
REQ-017 wb_ready_i  input  1  core can commit (no register-file structural conflict).
REQ-018 outstanding_o  output  $clog2(DEPTH_P+1)  accepted, uncommitted transactions; busy_o  output  1; error_o  output  1  sticky.

Function
REQ-019 A request SHALL be accepted when req_valid_i && req_ready_o; req_ready_o = (outstanding < DEPTH_P) && issue slot empty, or issue slot drains this cycle (mem_yumi_i).
REQ-020 The accepted request SHALL be registered into a single issue slot; mem_valid_o asserts the next cycle, zero-cycle combinational path forbidden.
REQ-021 mem_valid_o and all mem_* fields SHALL hold stable until the cycle mem_yumi_i is high; the slot then empties.
REQ-022 On acceptance, {tag, store, byte} SHALL be pushed into an in-order tag FIFO of depth DEPTH_P.
REQ-023 wb_valid_o = mem_rvalid_i && FIFO non-empty; wb_tag_o/wb_we_o from FIFO head; wb_we_o = !store.
REQ-024 mem_ryumi_o = wb_valid_o && wb_ready_i; on that cycle the FIFO SHALL pop and outstanding SHALL decrement.
REQ-025 Stores SHALL also complete through the response path (wb_we_o=0, wb_data_o=0).
REQ-026 Word loads: wb_data_o = mem_rdata_i; byte loads: low 8 bits extended per REQ-034.
REQ-027 Simultaneous accept and commit SHALL leave outstanding unchanged; FIFO pointers wrap modulo DEPTH_P.
REQ-028 mem_rvalid_i with empty FIFO SHALL set error_o (held until reset), assert no wb_valid_o, and still raise mem_ryumi_o to drop the response.
REQ-029 busy_o = (outstanding != 0) || mem_valid_o.
REQ-030 Throughput: with DEPTH_P>=2, mem_yumi_i always high and responses one cycle later, one request accepted per cycle.

Reset
REQ-031 On reset low, immediately: issue slot empty, FIFO empty, outstanding_o=0, mem_valid_o=0, mem_ryumi_o=0, wb_valid_o=0, busy_o=0, error_o=0, req_ready_o=1 after release.
REQ-032 Reset mid-transaction SHALL discard all in-flight state; late responses after release SHALL trigger REQ-028.

Configuration
REQ-033 Macro LSU_BYTE_SEXT_EN selects byte-load extension.
REQ-034 Defined: byte loads sign-extend bit 7 to DATA_WIDTH_P; undefined: byte loads zero-extend.

Structure
REQ-035 The request struct (lsu_req_s: store, byte, addr, wdata, tag) and the FIFO entry struct SHALL live in the shared definitions package.
REQ-036 The tag FIFO SHALL be a separate sub-module lsu_tag_fifo (push, pop, full, empty, head, count), parametrised by DEPTH_P.

Verification
REQ-037 Single load tag 3, addr 0x10; mem_yumi_i cycle 2, rvalid cycle 3 rdata 0xDEADBEEF, wb_ready_i=1 -> wb_valid_o, wb_tag_o=3, wb_data_o=0xDEADBEEF, outstanding 1->0.
REQ-038 DEPTH_P=2, three back-to-back loads, no responses -> third stalled (req_ready_o=0) until first commits.
REQ-039 Byte load rdata 0x000000F0 -> wb_data_o=0xFFFFFFF0 with LSU_BYTE_SEXT_EN, 0x000000F0 without.
REQ-040 mem_yumi_i held low 4 cycles -> mem_addr_o/mem_wdata_o unchanged, mem_valid_o high throughout.
REQ-041 Response with wb_ready_i=0 for 2 cycles -> mem_ryumi_o=0, FIFO unchanged; commits when wb_ready_i rises.
REQ-042 mem_rvalid_i with nothing outstanding -> error_o=1 next cycle, sticky until reset low.
